// File: rtl/spi_pkg.sv
// Shared defaults and FSM state type for the SPI slave agent.
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;
  localparam int SPI_CPOL       = 0;
  localparam int SPI_CPHA       = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, with single-cycle rise/fall
// pulses derived from the synchronized value.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave_agent.sv
// SPI slave with a one-word transmit holding register, all SPI inputs
// oversampled in the clk domain, and back-to-back words within one cs_n frame.
module spi_slave_agent
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int CPOL       = SPI_CPOL,
  parameter int CPHA       = SPI_CPHA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  underrun
);

  localparam int              CNT_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic            CPOL_LVL = (CPOL != 0);

  logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic w_cs_sync, w_cs_rise, w_cs_fall;

  // cs_n sync resets low so a cs_n held low through reset cannot start a frame.
  spi_sync_edge #(.RST_VAL(CPOL_LVL)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(sclk),
    .o_sync (w_sclk_sync),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(cs_n),
    .o_sync (w_cs_sync),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  logic r_mosi_meta, r_mosi_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_mosi_meta <= mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  logic w_sclk_edge, w_lead, w_trail, w_sample, w_shift;

  assign w_sclk_edge = w_sclk_rise | w_sclk_fall;
  assign w_lead      = w_sclk_edge & (w_sclk_sync != CPOL_LVL);
  assign w_trail     = w_sclk_edge & (w_sclk_sync == CPOL_LVL);
  assign w_sample    = (CPHA == 0) ? w_lead  : w_trail;
  assign w_shift     = (CPHA == 0) ? w_trail : w_lead;

  spi_state_t r_state, w_state_next;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_cs_fall) w_state_next = ST_ACTIVE;
      ST_ACTIVE: if (w_cs_sync) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  logic r_miso;

  always_comb begin
    miso_oe = 1'b0;
    busy    = 1'b0;
    miso    = 1'b0;
    if (r_state == ST_ACTIVE) begin
      miso_oe = 1'b1;
      busy    = 1'b1;
      miso    = r_miso;
    end
  end

  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-2:0] r_rx_shift;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_done, r_rx_valid;
  logic [DATA_WIDTH-1:0] r_hold, r_tx_shift;
  logic                  r_hold_full, r_underrun, r_under_pend;

  logic                  w_in_word, w_frame_end, w_last;
  logic                  w_word_start_cs, w_word_done, w_word_start;
  logic                  w_tx_load, w_shift_ok;
  logic [DATA_WIDTH-1:0] w_next_word, w_rx_next;

  assign w_in_word       = (r_state == ST_ACTIVE) & ~w_cs_sync;
  assign w_frame_end     = (r_state == ST_ACTIVE) & w_cs_rise;
  assign w_last          = (r_cnt == CNT_LAST);
  assign w_word_start_cs = (r_state == ST_IDLE) & w_cs_fall;
  assign w_word_done     = w_in_word & w_sample & w_last;
  assign w_word_start    = w_word_start_cs | w_word_done;
  assign w_tx_load       = tx_valid & ~r_hold_full;
  assign w_next_word     = r_hold_full ? r_hold : '0;
  assign w_rx_next       = {r_rx_shift, r_mosi_sync};
  // In CPHA=0 the MSB is already on miso from word start, so the trailing
  // edge that follows the last sample of a word must not shift it away.
  assign w_shift_ok      = w_in_word & w_shift & ((CPHA != 0) | (r_cnt != '0));

  assign tx_ready = ~r_hold_full;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign underrun = r_underrun;

  // Underrun for a word chained after completion is reported only once that
  // word actually clocks a bit, so a frame ending cleanly does not flag one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_tx_shift   <= '0;
      r_miso       <= 1'b0;
      r_underrun   <= 1'b0;
      r_under_pend <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (w_word_start) r_hold_full <= 1'b0;
      if (w_tx_load) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end
      if (w_word_start) begin
        if (CPHA == 0) begin
          r_miso     <= w_next_word[DATA_WIDTH-1];
          r_tx_shift <= w_next_word << 1;
        end else begin
          r_tx_shift <= w_next_word;
        end
        r_underrun   <= w_word_start_cs & ~r_hold_full;
        r_under_pend <= w_word_done & ~r_hold_full;
      end else if (w_shift_ok) begin
        r_miso     <= r_tx_shift[DATA_WIDTH-1];
        r_tx_shift <= r_tx_shift << 1;
      end
      if (w_frame_end) begin
        r_under_pend <= 1'b0;
      end else if (r_under_pend && w_in_word && w_sample && !w_word_start) begin
        r_underrun   <= 1'b1;
        r_under_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_done  <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_done  <= 1'b0;
      r_rx_valid <= r_rx_done;
      if (w_frame_end) begin
        r_cnt <= '0;
      end else if (w_in_word && w_sample) begin
        r_rx_shift <= w_rx_next[DATA_WIDTH-2:0];
        if (w_last) begin
          r_cnt     <= '0;
          r_rx_data <= w_rx_next;
          r_rx_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_agent.sv
// Drives a mode-0 and a mode-3 slave as an SPI master and compares every
// received word and miso word against values computed from the SPI rules.
module tb_spi_slave_agent;

  localparam int HALF = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic       sclk0 = 1'b0, cs0_n = 1'b1, mosi0 = 1'b0, tx_valid0 = 1'b0;
  logic [7:0] tx_data0 = '0;
  logic       miso0, miso_oe0, tx_ready0, rx_valid0, busy0, underrun0;
  logic [7:0] rx_data0;

  logic       sclk3 = 1'b1, cs3_n = 1'b1, mosi3 = 1'b0, tx_valid3 = 1'b0;
  logic [7:0] tx_data3 = '0;
  logic       miso3, miso_oe3, tx_ready3, rx_valid3, busy3, underrun3;
  logic [7:0] rx_data3;

  spi_slave_agent #(.DATA_WIDTH(8), .CPOL(0), .CPHA(0)) dut0 (
    .clk(clk), .rst(rst), .sclk(sclk0), .cs_n(cs0_n), .mosi(mosi0),
    .miso(miso0), .miso_oe(miso_oe0), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .busy(busy0), .underrun(underrun0)
  );

  spi_slave_agent #(.DATA_WIDTH(8), .CPOL(1), .CPHA(1)) dut3 (
    .clk(clk), .rst(rst), .sclk(sclk3), .cs_n(cs3_n), .mosi(mosi3),
    .miso(miso3), .miso_oe(miso_oe3), .tx_data(tx_data3), .tx_valid(tx_valid3),
    .tx_ready(tx_ready3), .rx_data(rx_data3), .rx_valid(rx_valid3),
    .busy(busy3), .underrun(underrun3)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] rxq0[$];
  logic [7:0] rxq3[$];
  int ucnt0 = 0, ucnt3 = 0;
  int qbase, ubase;

  always @(negedge clk) begin
    if (rx_valid0) rxq0.push_back(rx_data0);
    if (rx_valid3) rxq3.push_back(rx_data3);
    if (underrun0) ucnt0++;
    if (underrun3) ucnt3++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_sclk(input bit m3, input logic v);
    if (m3) sclk3 = v; else sclk0 = v;
  endtask
  task automatic set_cs(input bit m3, input logic v);
    if (m3) cs3_n = v; else cs0_n = v;
  endtask
  task automatic set_mosi(input bit m3, input logic v);
    if (m3) mosi3 = v; else mosi0 = v;
  endtask

  function automatic logic get_miso(input bit m3);
    return m3 ? miso3 : miso0;
  endfunction
  function automatic logic get_ready(input bit m3);
    return m3 ? tx_ready3 : tx_ready0;
  endfunction
  function automatic logic [1:0] get_busy_oe(input bit m3);
    return m3 ? {busy3, miso_oe3} : {busy0, miso_oe0};
  endfunction
  function automatic int qsize(input bit m3);
    return m3 ? rxq3.size() : rxq0.size();
  endfunction
  function automatic logic [7:0] qword(input bit m3, input int idx);
    logic [7:0] w;
    w = 8'hxx;
    if (m3) begin
      if (idx < rxq3.size()) w = rxq3[idx];
    end else begin
      if (idx < rxq0.size()) w = rxq0[idx];
    end
    return w;
  endfunction

  task automatic mark(input bit m3);
    qbase = qsize(m3);
    ubase = m3 ? ucnt3 : ucnt0;
  endtask

  task automatic check_rx(input bit m3, input string tag, input int n, input logic [15:0] exp);
    check({tag, "_rxcnt"}, 16'(qsize(m3) - qbase), 16'(n));
    for (int i = 0; i < n; i++)
      check({tag, "_rxword"}, {8'h00, qword(m3, qbase + i)}, {8'h00, exp[8*(n-1-i) +: 8]});
  endtask

  task automatic check_under(input bit m3, input string tag, input int n);
    check({tag, "_underrun"}, 16'((m3 ? ucnt3 : ucnt0) - ubase), 16'(n));
  endtask

  // Master clocking of n bits MSB first; mosi changes on falling sclk, miso
  // is sampled on rising sclk for both modes used here.
  task automatic clk_bits(input bit m3, input int n, input logic [15:0] din, output logic [15:0] dout);
    logic [15:0] acc;
    acc = '0;
    if (!m3) begin
      set_mosi(0, din[n-1]);
      #HALF;
    end
    for (int i = n - 1; i >= 0; i--) begin
      if (m3) begin
        set_sclk(1, 1'b0);
        set_mosi(1, din[i]);
        #HALF;
        set_sclk(1, 1'b1);
        acc = {acc[14:0], get_miso(1)};
        #HALF;
      end else begin
        set_sclk(0, 1'b1);
        acc = {acc[14:0], get_miso(0)};
        #HALF;
        set_sclk(0, 1'b0);
        if (i > 0) set_mosi(0, din[i-1]);
        #HALF;
      end
    end
    dout = acc;
  endtask

  task automatic spi_frame(input bit m3, input int n, input logic [15:0] din, output logic [15:0] dout);
    @(negedge clk);
    set_cs(m3, 1'b0);
    #80;
    check("frame_busy_oe", {14'h0, get_busy_oe(m3)}, 16'h0003);
    clk_bits(m3, n, din, dout);
    #40;
    set_cs(m3, 1'b1);
    #100;
  endtask

  task automatic load_tx(input bit m3, input logic [7:0] d);
    int k;
    k = 0;
    @(negedge clk);
    while (!get_ready(m3) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("tx_ready_wait", {15'h0, get_ready(m3)}, 16'h0001);
    if (m3) begin tx_data3 = d; tx_valid3 = 1'b1; end
    else    begin tx_data0 = d; tx_valid0 = 1'b1; end
    @(negedge clk);
    tx_valid0 = 1'b0;
    tx_valid3 = 1'b0;
    check("tx_ready_fall", {15'h0, get_ready(m3)}, 16'h0000);
  endtask

  logic [15:0] got, got2;
  logic [7:0]  rtx, rrx;
  bit          rm3, rload;

  initial begin
    repeat (4) @(negedge clk);
    check("reset_status0", {9'h0, miso0, miso_oe0, rx_valid0, tx_ready0, busy0, underrun0, 1'b0}, 16'h0008);
    check("reset_rxdata0", {8'h00, rx_data0}, 16'h0000);
    check("reset_status3", {9'h0, miso3, miso_oe3, rx_valid3, tx_ready3, busy3, underrun3, 1'b0}, 16'h0008);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Mode 0 single word
    mark(0);
    load_tx(0, 8'hA5);
    spi_frame(0, 8, 16'h003C, got);
    check("m0_miso", got, 16'h00A5);
    check_rx(0, "m0", 1, 16'h003C);
    check_under(0, "m0", 0);

    // Back-to-back words in one frame; second word loaded during the first
    mark(0);
    load_tx(0, 8'h11);
    fork
      spi_frame(0, 16, 16'hF00F, got);
      load_tx(0, 8'h22);
    join
    check("b2b_miso", got, 16'h1122);
    check_rx(0, "b2b", 2, 16'hF00F);
    check_under(0, "b2b", 0);

    // Nothing loaded: zeros shifted out, one underrun
    mark(0);
    spi_frame(0, 8, 16'h005B, got);
    check("under_miso", got, 16'h0000);
    check_rx(0, "under", 1, 16'h005B);
    check_under(0, "under", 1);

    // Aborted partial word, then a full word
    mark(0);
    spi_frame(0, 5, 16'h0013, got);
    check_rx(0, "abort", 0, 16'h0000);
    load_tx(0, 8'h6E);
    spi_frame(0, 8, 16'h0081, got);
    check("abort_next_miso", got, 16'h006E);
    check_rx(0, "abort_next", 1, 16'h0081);
    check_under(0, "abort", 1);

    // CPOL=1, CPHA=1
    mark(1);
    load_tx(1, 8'h5A);
    spi_frame(1, 8, 16'h00C3, got);
    check("m3_miso", got, 16'h005A);
    check_rx(1, "m3", 1, 16'h00C3);
    check_under(1, "m3", 0);

    // Reset in the middle of a frame
    mark(0);
    load_tx(0, 8'h77);
    @(negedge clk);
    set_cs(0, 1'b0);
    #80;
    clk_bits(0, 3, 16'h0005, got);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_status", {9'h0, miso0, miso_oe0, rx_valid0, tx_ready0, busy0, underrun0, 1'b0}, 16'h0008);
    check("midrst_rxdata", {8'h00, rx_data0}, 16'h0000);
    clk_bits(0, 8, 16'h00FF, got);
    #40;
    check("midrst_busy", {15'h0, busy0}, 16'h0000);
    check_rx(0, "midrst", 0, 16'h0000);
    set_cs(0, 1'b1);
    #100;
    mark(0);
    load_tx(0, 8'h39);
    spi_frame(0, 8, 16'h00D2, got);
    check("postrst_miso", got, 16'h0039);
    check_rx(0, "postrst", 1, 16'h00D2);

    // Randomized words on both modes
    for (int it = 0; it < 8; it++) begin
      rm3   = 1'($urandom_range(0, 1));
      rload = 1'($urandom_range(0, 1));
      rtx   = 8'($urandom);
      rrx   = 8'($urandom);
      mark(rm3);
      if (rload) load_tx(rm3, rtx);
      spi_frame(rm3, 8, {8'h00, rrx}, got2);
      check("rand_miso", got2, rload ? {8'h00, rtx} : 16'h0000);
      check_rx(rm3, "rand", 1, {8'h00, rrx});
      check_under(rm3, "rand", rload ? 0 : 1);
    end

    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave_agent.md
SPI_SLAVE_AGENT -- requirements
Module: spi_slave_agent

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high; the ports are named clk and rst.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the bits per SPI word.
REQ-003 Parameter CPOL, default 0, SHALL set the sclk idle level.
REQ-004 Parameter CPHA, default 0, SHALL select the sample edge: 0 = leading edge, 1 = trailing edge.
REQ-005 clk  in  1  system clock; all logic is clocked on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 sclk  in  1  SPI serial clock from the master, asynchronous to clk.
REQ-008 cs_n  in  1  chip select from the master, active-low, asynchronous.
REQ-009 mosi  in  1  serial data from the master, asynchronous.
REQ-010 miso  out  1  serial data to the master, MSB first.
REQ-011 miso_oe  out  1  miso output enable; high only while the slave is selected.
REQ-012 tx_data  in  DATA_WIDTH  next word to transmit.
REQ-013 tx_valid  in  1  tx_data is valid.
REQ-014 tx_ready  out  1  the transmit holding register is empty.
REQ-015 rx_data  out  DATA_WIDTH  last fully received word.
REQ-016 rx_valid  out  1  one-cycle pulse: rx_data has been updated.
REQ-017 busy  out  1  a frame is active (synchronized cs_n is low).
REQ-018 underrun  out  1  one-cycle pulse: a word started while the holding register was empty.

Function
REQ-019 sclk, cs_n and mosi SHALL each pass through a 2-flop synchronizer; sclk edges SHALL be detected on the synchronized value.
REQ-020 clk SHALL be at least 4x the sclk frequency; behaviour below this ratio is unspecified.
REQ-021 Leading edge = sclk leaving its CPOL level; trailing edge = sclk returning to it. The shift edge is the edge that is not the sample edge.
REQ-022 The FSM SHALL have the states IDLE and ACTIVE: IDLE->ACTIVE on a synchronized cs_n falling edge; ACTIVE->IDLE on synchronized cs_n high.
REQ-023 Transmit handshake: when tx_valid and tx_ready are both high, tx_data SHALL be loaded into the holding register, and tx_ready SHALL fall on the next cycle.
REQ-024 At word start (the IDLE->ACTIVE transition, or completion of the previous word), the holding register SHALL move to the TX shift register and tx_ready SHALL rise.
REQ-025 If the holding register is empty at word start, the shift register SHALL load all zeros and underrun SHALL pulse for one cycle.
REQ-026 With CPHA=0, the MSB SHALL be on miso in the cycle after word start; each subsequent shift edge SHALL present the next bit.
REQ-027 With CPHA=1, the first shift edge SHALL present the MSB.
REQ-028 On each sample edge, mosi SHALL be shifted into the RX register and the bit counter (0..DATA_WIDTH-1) SHALL increment.
REQ-029 On the DATA_WIDTH-th sample edge: rx_data SHALL update, rx_valid SHALL pulse 1 cycle later, the counter SHALL wrap to 0, and the next word SHALL start (back-to-back frames are supported).
REQ-030 cs_n rising mid-word SHALL discard the partial word (no rx_valid), clear the counter and enter IDLE; a loaded holding register SHALL be retained.
REQ-031 rx_valid SHALL NOT be back-pressured; a new word overwrites rx_data.
REQ-032 When not ACTIVE: miso=0, miso_oe=0.
REQ-033 A tx load in the same cycle as word start SHALL go to the holding register for the following word.

Reset
REQ-034 On rst, outputs SHALL be: miso=0, miso_oe=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0, underrun=0; FSM=IDLE; counter=0; holding register empty.
REQ-035 Reset during a frame SHALL abort it; a new frame SHALL begin only after cs_n is seen high and then falls again.

Structure
REQ-036 Package spi_pkg SHALL hold the DATA_WIDTH default, the CPOL/CPHA defaults and the FSM state enum.
REQ-037 A sub-module spi_sync_edge (2-flop synchronizer with rise/fall pulses) SHALL be instantiated for sclk and cs_n.

Verification
REQ-038 Mode 0, tx 0xA5 loaded, master sends 0x3C: rx_data=0x3C with one rx_valid pulse; master receives 0xA5.
REQ-039 Back-to-back frame, tx 0x11 then 0x22, mosi 0xF0 then 0x0F: two rx_valid pulses with 0xF0 then 0x0F; miso sends 0x11 then 0x22.
REQ-040 No tx loaded, 8-bit frame: underrun pulses once; miso=0x00.
REQ-041 cs_n deasserted after 5 bits: no rx_valid; the next full frame of 0x81 yields rx_data=0x81.
REQ-042 CPOL=1, CPHA=1, tx 0x5A, mosi 0xC3: rx_data=0xC3; master receives 0x5A.
REQ-043 rst asserted mid-frame: all outputs at reset values next cycle; no rx_valid until cs_n toggles high then low.
